// File: rtl/seq_cycle_fsm.sv
// Cyclic-sequence state machine: walks a W-bit state through the ordered
// table SEQ forward, in reverse, ping-pong or holding, with load and wrap flag.
module seq_cycle_fsm #(
  parameter int             W   = 3,
  parameter int             LEN = 5,
  parameter logic [LEN*W-1:0] SEQ = {3'd1, 3'd3, 3'd7, 3'd6, 3'd0},
  localparam int            IW  = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [W-1:0]  load_state,
  input  logic [1:0]    mode,
  output logic [W-1:0]  state,
  output logic [IW-1:0] pos,
  output logic          in_seq,
  output logic          dir,
  output logic          wrap
);

  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_REV  = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  mode_e         mode_w;
  logic [W-1:0]  state_q, state_d;
  logic [IW-1:0] pos_q, pos_d;
  logic          in_seq_q, in_seq_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          hit;
  logic [IW-1:0] hit_idx;

  assign mode_w = mode_e'(mode);

  // Scan high to low so the lowest matching index wins on duplicates.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (SEQ[i*W +: W] == load_state) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    in_seq_d = in_seq_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    if (load) begin
      state_d  = load_state;
      pos_d    = hit ? hit_idx : '0;
      in_seq_d = hit;
    end else if (en && (mode_w != MODE_HOLD)) begin
      in_seq_d = 1'b1;
      if (!in_seq_q) begin
        // Re-entry from an off-table value starts at the natural end.
        if (mode_w == MODE_REV) begin
          pos_d = LAST;
          dir_d = 1'b1;
        end else begin
          pos_d = '0;
          dir_d = 1'b0;
        end
      end else begin
        case (mode_w)
          MODE_FWD: begin
            dir_d = 1'b0;
            if (pos_q == LAST) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + IW'(1);
            end
          end
          MODE_REV: begin
            dir_d = 1'b1;
            if (pos_q == '0) begin
              pos_d  = LAST;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - IW'(1);
            end
          end
          MODE_PING: begin
            if (LEN == 1) begin
              pos_d  = '0;
              dir_d  = ~dir_q;
              wrap_d = 1'b1;
            end else if (!dir_q) begin
              if (pos_q == LAST) begin
                pos_d  = LAST - IW'(1);
                dir_d  = 1'b1;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q + IW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d  = IW'(1);
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q - IW'(1);
              end
            end
          end
          default: ;
        endcase
      end
      state_d = SEQ[int'(pos_d)*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEQ[W-1:0];
      pos_q    <= '0;
      in_seq_q <= 1'b1;
      dir_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      in_seq_q <= in_seq_d;
      dir_q    <= dir_d;
      wrap_q   <= wrap_d;
    end
  end

  assign state  = state_q;
  assign pos    = pos_q;
  assign in_seq = in_seq_q;
  assign dir    = dir_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_seq_cycle_fsm.sv
// Randomised and directed bench for seq_cycle_fsm: a table-walking reference
// model feeds an expected queue drained by an independent monitor.
module tb_seq_cycle_fsm;

  localparam int W   = 3;
  localparam int LEN = 5;
  localparam int IW  = 3;
  localparam int EW  = W + IW + 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [W-1:0]  load_state = '0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  state;
  logic [IW-1:0] pos;
  logic          in_seq, dir, wrap;

  seq_cycle_fsm u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_state(load_state),
    .mode(mode), .state(state), .pos(pos), .in_seq(in_seq), .dir(dir),
    .wrap(wrap)
  );

  // single-entry build
  logic         o_rst = 1'b1, o_en = 1'b0, o_load = 1'b0;
  logic [2:0]   o_ls = '0;
  logic [1:0]   o_mode = 2'b00;
  logic [2:0]   o_state;
  logic [0:0]   o_pos;
  logic         o_in, o_dir, o_wrap;

  seq_cycle_fsm #(.W(3), .LEN(1), .SEQ(3'd5)) u_one (
    .clk(clk), .rst(o_rst), .en(o_en), .load(o_load), .load_state(o_ls),
    .mode(o_mode), .state(o_state), .pos(o_pos), .in_seq(o_in), .dir(o_dir),
    .wrap(o_wrap)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {state,pos,in,dir,wrap}=%0h/%0d/%0b/%0b/%0b required %0h/%0d/%0b/%0b/%0b",
               name, act[EW-1 -: W], act[IW+2:3], act[2], act[1], act[0],
               exp[EW-1 -: W], exp[IW+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // reference model: table walk in index space
  int tbl[LEN] = '{0, 6, 7, 3, 1};
  int m_state = 0, m_pos = 0;
  bit m_in = 1, m_dir = 0, m_wrap = 0;

  task automatic model(input bit r, input bit l, input int ls, input bit e,
                       input int m);
    m_wrap = 0;
    if (r) begin
      m_pos = 0; m_state = tbl[0]; m_in = 1; m_dir = 0;
    end else if (l) begin
      m_state = ls; m_in = 0; m_pos = 0;
      for (int i = 0; i < LEN; i++)
        if (!m_in && tbl[i] == ls) begin m_in = 1; m_pos = i; end
    end else if (e && m != 3) begin
      if (!m_in) begin
        m_dir = (m == 1);
        m_pos = (m == 1) ? LEN - 1 : 0;
      end else if (m == 0) begin
        m_wrap = (m_pos == LEN - 1); m_pos = (m_pos + 1) % LEN; m_dir = 0;
      end else if (m == 1) begin
        m_wrap = (m_pos == 0); m_pos = (m_pos + LEN - 1) % LEN; m_dir = 1;
      end else begin
        int nxt = m_dir ? m_pos - 1 : m_pos + 1;
        if (nxt < 0 || nxt >= LEN) begin
          m_dir = ~m_dir; m_wrap = 1;
          nxt = m_dir ? m_pos - 1 : m_pos + 1;
        end
        m_pos = nxt;
      end
      m_in = 1;
      m_state = tbl[m_pos];
    end
  endtask

  // driver
  task automatic drive(input bit r, input bit l, input int ls, input bit e,
                       input int m, input string tag);
    @(negedge clk);
    rst = r; load = l; load_state = W'(ls); en = e; mode = 2'(m);
    model(r, l, ls, e, m);
    exp_q.push_back({W'(m_state), IW'(m_pos), m_in, m_dir, m_wrap});
    tag_q.push_back(tag);
  endtask

  // monitor: one registered result per edge that consumed a stimulus
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0)
        check(tag_q.pop_front(), {state, pos, in_seq, dir, wrap},
              exp_q.pop_front());
    end
  end

  task automatic check_one(input string name, input bit [2:0] s, input bit w);
    @(posedge clk);
    #1;
    check(name, {EW'(o_state), 1'b0, 1'b0, 1'b0, o_pos[0], o_in, o_wrap},
          {EW'(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w});
  endtask

  initial begin
    int budget;
    // 1 reset then forward
    drive(1, 0, 0, 0, 0, "reset0");
    drive(1, 0, 0, 1, 0, "reset1");
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0, "fwd");
    // 2 reverse from state 0
    drive(0, 1, 0, 0, 0, "load0");
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, "rev");
    // 3 ping-pong from idx0 with dir cleared by reset
    drive(1, 0, 0, 0, 0, "reset_pp");
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 2, "pingpong");
    // ping-pong continuing from a reverse-set dir
    drive(0, 1, 7, 0, 0, "load7");
    drive(0, 0, 0, 1, 1, "rev_dir");
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 2, "pp_down");
    // 4 off-table load and recovery
    drive(0, 1, 5, 0, 0, "load_off");
    drive(0, 0, 0, 1, 0, "off_fwd");
    drive(0, 1, 5, 1, 2, "load_off2");
    drive(0, 0, 0, 1, 1, "off_rev");
    drive(0, 1, 4, 0, 0, "load_off3");
    drive(0, 0, 0, 1, 2, "off_pp");
    // 5 load beats step, then hold
    drive(0, 1, 7, 1, 0, "load_prio");
    drive(0, 0, 0, 0, 0, "hold_en");
    drive(0, 0, 0, 1, 3, "hold_mode");
    drive(0, 0, 0, 1, 3, "hold_mode2");
    // 6 reset beats load mid-run
    drive(0, 1, 3, 0, 0, "load3");
    drive(1, 1, 6, 1, 0, "reset_prio");
    // randomised traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), "random");
    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d left, required 0", exp_q.size());
    end

    // single-entry table: index stays 0, every step wraps
    @(negedge clk);
    o_rst = 1'b1;
    check_one("one_reset", 3'd5, 1'b0);
    @(negedge clk);
    o_rst = 1'b0; o_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      o_mode = 2'(i % 3);
      check_one("one_step", 3'd5, 1'b1);
      @(negedge clk);
    end
    o_en = 1'b0;
    check_one("one_hold", 3'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
